nibble_serial_subtractor: RTL and testbench
===========================================

Name: nibble_serial_subtractor

Overview:
- Multi-cycle subtractor. Computes DIFF = A - B - borrow_in over WIDTH bits, one 4-bit slice per clock, with ripple-borrow between slices.
- Complements the team's ripple-carry adder blocks and gives the ALU datapath a subtract path.
- Uses a start/done handshake so a sequencing FSM can issue operations and collect the result.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4 (localparam), number of 4-bit slices, which equals the RUN latency in cycles.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  input  1  operation request; honoured only in IDLE.
- a  input  WIDTH  minuend; sampled on the edge that accepts start.
- b  input  WIDTH  subtrahend; sampled with a.
- borrow_in  input  1  incoming borrow; sampled with a.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result outputs are valid in that cycle.
- diff  output  WIDTH  A - B - borrow_in, modulo 2^WIDTH.
- borrow_out  output  1  1 when the unsigned A < B + borrow_in.
- zero  output  1  1 when diff == 0.
- overflow  output  1  signed overflow (see Optional Feature).

Behaviour:
- Reset (rst_n == 0 at a rising edge): state = IDLE.
  - busy = 0, done = 0, diff = 0, borrow_out = 0, zero = 0, overflow = 0.
  - Internal operand registers, slice index and borrow register cleared.
  - Reset overrides start. Reset in any state, including mid-RUN, aborts the operation with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start == 1 at an edge: latch a, b, borrow_in; slice index k = 0; borrow register = borrow_in; go to RUN.
  - Otherwise hold. diff, borrow_out, zero and overflow keep the last result.
- RUN (busy = 1): at each edge, slice k (bits 4k+3..4k) is computed as a_k + ~b_k + ~borrow.
  - The 4-bit sum is written into the diff slice. The new borrow = NOT (carry out of that sum).
  - k increments.
  - At the edge processing k = NIB-1, go to DONE.
  - diff may show partial results during RUN; consumers use it only when done == 1.
- DONE (done = 1 for exactly one cycle, busy = 0):
  - borrow_out = final borrow; zero = (diff == 0).
  - Next edge goes to IDLE unconditionally.
- Latency: start sampled at edge 0; DONE entered at edge NIB. For WIDTH = 16, done is high in the cycle after edge 4.
- Minimum issue interval is NIB + 2 cycles.
- start is ignored (no queueing, no effect) in RUN and DONE.
- Input changes on a, b, borrow_in after the accepting edge have no effect.
- Results hold in IDLE until the next DONE overwrites them.
- Arithmetic is unsigned modulo 2^WIDTH.
  - A = B with borrow_in = 1 gives all-ones with borrow_out = 1.
  - A = 0, B = 2^WIDTH-1, borrow_in = 1 gives diff = 0, borrow_out = 1, zero = 1.

Optional Feature:
- Macro: SUB_OVERFLOW_EN.
- Defined:
  - The top slice also records signed overflow: (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the latched operands.
  - overflow is registered in DONE, held in IDLE, and cleared by reset.
- Undefined:
  - The overflow port remains but is tied to 0.
  - No overflow logic is synthesised.

Test Plan:
- WIDTH=16, a=0x1234, b=0x0234, borrow_in=0, start pulsed -> busy high 4 cycles, then done=1 for one cycle with diff=0x1000, borrow_out=0, zero=0.
- a=0x0000, b=0x0001, borrow_in=0 -> diff=0xFFFF, borrow_out=1, zero=0. Next: a=b=0xABCD -> diff=0x0000, zero=1, borrow_out=0.
- a=0x0005, b=0x0005, borrow_in=1 -> diff=0xFFFF, borrow_out=1. Also a=0x0010, b=0x000F, borrow_in=1 -> diff=0x0000, zero=1 (borrow crosses slice 0→1).
- start held high continuously with changing a/b -> operands are captured only at IDLE-accepting edges; exactly one done per NIB+2 cycles; mid-RUN operand changes do not alter diff.
- rst_n driven low for one edge during RUN cycle 2 -> next cycle all outputs 0, state IDLE, no done pulse; a following start completes normally.
- With SUB_OVERFLOW_EN: a=0x8000, b=0x0001 -> diff=0x7FFF, overflow=1, borrow_out=0; a=0x7FFF, b=0xFFFF -> diff=0x8000, overflow=1. Without the macro: overflow stays 0 for both.

Source files
------------

// File: rtl/nibble_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_subtractor
// Brief    : Multi-cycle A - B - borrow_in, one 4-bit slice per clock, with a
//            start/done handshake. Optional signed overflow: SUB_OVERFLOW_EN.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero,
    output logic             overflow
);

    localparam int NIB = WIDTH / 4;
    localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [KW-1:0] LAST_K = KW'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [KW-1:0]    r_k;
    logic             r_borrow;

    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [4:0]       w_sum;
    logic             w_borrow_next;
    logic [WIDTH-1:0] w_diff_next;

    // Subtraction as a + ~b + ~borrow: the carry out is the inverted borrow.
    always_comb begin
        w_a_nib       = r_a[4*r_k +: 4];
        w_b_nib       = r_b[4*r_k +: 4];
        w_sum         = {1'b0, w_a_nib} + {1'b0, ~w_b_nib} + {4'b0000, ~r_borrow};
        w_borrow_next = ~w_sum[4];
        w_diff_next   = diff;
        w_diff_next[4*r_k +: 4] = w_sum[3:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_k        <= '0;
            r_borrow   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            zero       <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            overflow   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_k      <= '0;
                        r_borrow <= borrow_in;
                        busy     <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    diff     <= w_diff_next;
                    r_borrow <= w_borrow_next;
                    r_k      <= r_k + 1'b1;
                    if (r_k == LAST_K) begin
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        borrow_out <= w_borrow_next;
                        zero       <= (w_diff_next == '0);
`ifdef SUB_OVERFLOW_EN
                        // Top slice sum bit 3 is the result sign bit.
                        overflow   <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                                      (w_sum[3] != r_a[WIDTH-1]);
`endif
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifndef SUB_OVERFLOW_EN
    assign overflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_subtractor
// Brief    : Self-checking bench: arithmetic/latency model plus directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_subtractor;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             zero;
    logic             overflow;

    int n_checks = 0;
    int n_fail   = 0;

    nibble_serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .zero       (zero),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: result from plain arithmetic, timing from the accept edge.
    bit               m_init  = 0;
    int               m_phase = -1;
    logic [WIDTH-1:0] m_pdiff;
    logic             m_pbout;
    logic             m_povf;
    logic [WIDTH-1:0] m_diff;
    logic             m_bout;
    logic             m_zero;
    logic             m_ovf;

    always @(posedge clk) begin
        logic [WIDTH:0] t;
        if (!rst_n) begin
            m_init  = 1;
            m_phase = -1;
            m_diff  = '0;
            m_bout  = 0;
            m_zero  = 0;
            m_ovf   = 0;
        end else if (m_init) begin
            if (m_phase < 0) begin
                if (start) begin
                    t       = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, borrow_in};
                    m_pdiff = t[WIDTH-1:0];
                    m_pbout = t[WIDTH];
`ifdef SUB_OVERFLOW_EN
                    m_povf  = (a[WIDTH-1] != b[WIDTH-1]) && (t[WIDTH-1] != a[WIDTH-1]);
`else
                    m_povf  = 0;
`endif
                    m_phase = 0;
                end
            end else begin
                m_phase++;
                if (m_phase == NIB) begin
                    m_diff = m_pdiff;
                    m_bout = m_pbout;
                    m_zero = (m_pdiff == '0);
                    m_ovf  = m_povf;
                end else if (m_phase > NIB) begin
                    m_phase = -1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("model_busy", {31'd0, busy}, {31'd0, (m_phase >= 0 && m_phase < NIB)});
            chk("model_done", {31'd0, done}, {31'd0, (m_phase == NIB)});
            if (!(m_phase >= 0 && m_phase < NIB))
                chk("model_diff", {16'd0, diff}, {16'd0, m_diff});
            chk("model_borrow", {31'd0, borrow_out}, {31'd0, m_bout});
            chk("model_zero", {31'd0, zero}, {31'd0, m_zero});
            chk("model_ovf", {31'd0, overflow}, {31'd0, m_ovf});
        end
    end

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tbin,
                          input logic [15:0] ed, input logic eb, input logic ez, input logic eo);
        bit found;
        int nbusy;
        @(posedge clk); #2;
        a = ta; b = tb_v; borrow_in = tbin; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0; a = ~ta; b = ~tb_v; borrow_in = ~tbin;
        found = 0;
        nbusy = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (done) found = 1;
            else if (busy) nbusy++;
        end
        chk("done_seen", {31'd0, found}, 32'd1);
        chk("busy_cycles", nbusy, NIB);
        if (found) begin
            chk("diff", {16'd0, diff}, {16'd0, ed});
            chk("borrow_out", {31'd0, borrow_out}, {31'd0, eb});
            chk("zero", {31'd0, zero}, {31'd0, ez});
            chk("overflow", {31'd0, overflow}, {31'd0, eo});
        end
    endtask

`ifdef SUB_OVERFLOW_EN
    localparam logic OV = 1'b1;
`else
    localparam logic OV = 1'b0;
`endif

    initial begin
        int n_done;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_diff", {16'd0, diff}, 32'd0);
        chk("rst_borrow", {31'd0, borrow_out}, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);

        run_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
        run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        run_op(16'hABCD, 16'hABCD, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        run_op(16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        run_op(16'h0010, 16'h000F, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0);
        run_op(16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, OV);
        run_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, OV);
        run_op(16'h5555, 16'h5555, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);

        // start held high with operands changing every cycle
        @(posedge clk); #2;
        start  = 1'b1;
        n_done = 0;
        for (int i = 0; i < 18; i++) begin
            a         = 16'(i * 16'h0F1D + 16'h2345);
            b         = 16'(i * 16'h3A07);
            borrow_in = (i % 2) == 1;
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                n_done++;
                if (n_done == 1) chk("hold_first_diff", {16'd0, diff}, 32'h2345);
            end
        end
        start = 1'b0;
        chk("hold_done_count", n_done, 3);

        // reset in the middle of RUN
        repeat (3) @(posedge clk);
        #2 a = 16'h1111; b = 16'h0001; borrow_in = 1'b0; start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        @(posedge clk); #2 rst_n = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_diff", {16'd0, diff}, 32'd0);
        chk("abort_borrow", {31'd0, borrow_out}, 32'd0);
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("abort_no_done", n_done, 0);

        run_op(16'h4321, 16'h1234, 1'b1, 16'h30EC, 1'b0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        chk("hold_idle_diff", {16'd0, diff}, 32'h30EC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
